// File: rtl/fp_pkg.sv
// ============================================================================
// Module      : fp_pkg
// Description : Shared IEEE-754 single-precision types and FSM state encoding
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fp_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_NORM  = 3'd2,
    ST_ROUND = 3'd3,
    ST_SEND  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
  } fp32_t;

endpackage

`default_nettype wire

// File: rtl/int2fp_core.sv
// ============================================================================
// Module      : int2fp_core
// Description : Two-stage signed int32 to fp32 converter, round-to-nearest-even
// Revision    : 1.0
// ============================================================================
`default_nettype none

module int2fp_core
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [31:0] i_data,
  output fp32_t       o_fp
);

  logic [31:0] w_mag;
  logic [4:0]  w_msb;
  logic        r_sign;
  logic [31:0] r_mag;
  logic [4:0]  r_msb;
  logic [31:0] w_norm;
  logic        w_up;
  logic [24:0] w_mant;
  logic [7:0]  w_exp;
  logic        w_zero;
  fp32_t       r_fp;

  // 0x80000000 negates to itself, which read as unsigned is exactly 2^31.
  assign w_mag = i_data[31] ? (~i_data + 32'd1) : i_data;

  always_comb begin
    w_msb = '0;
    for (int i = 0; i < 32; i++) begin
      if (w_mag[i]) w_msb = 5'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
      r_mag  <= '0;
      r_msb  <= '0;
    end else if (i_en) begin
      r_sign <= i_data[31];
      r_mag  <= w_mag;
      r_msb  <= w_msb;
    end
  end

  // Leading one lands on bit 31; bits [7:0] hold guard and sticky, zero when exact.
  assign w_norm = r_mag << (5'd31 - r_msb);
  assign w_up   = w_norm[7] & ((|w_norm[6:0]) | w_norm[8]);
  assign w_mant = {1'b0, w_norm[31:8]} + {24'd0, w_up};
  assign w_exp  = 8'(FP_BIAS) + {3'd0, r_msb} + {7'd0, w_mant[24]};
  assign w_zero = ~(w_mant[24] | w_mant[23]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fp <= '0;
    end else if (i_en) begin
      if (w_zero) begin
        r_fp <= '0;
      end else begin
        r_fp.sign <= r_sign;
        r_fp.exp  <= w_exp;
        r_fp.mant <= w_mant[22:0];
      end
    end
  end

  assign o_fp = r_fp;

endmodule

`default_nettype wire

// File: rtl/int2fp_stream_tx.sv
// ============================================================================
// Module      : int2fp_stream_tx
// Description : Integer frame buffer streamed as fp32 words over AXI-Stream
// Revision    : 1.0
// ============================================================================
`default_nettype none

module int2fp_stream_tx
  import fp_pkg::*;
#(
  parameter int SIZE       = 10,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = $clog2(SIZE)
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [31:0]           wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  m00_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m00_axis_tdata,
  output logic [3:0]            m00_axis_tstrb,
  output logic                  m00_axis_tlast,
  input  logic                  m00_axis_tready
);

  localparam logic [AW-1:0] c_last_idx = AW'(SIZE - 1);
  localparam logic [AW:0]   c_size     = (AW + 1)'(SIZE);

  logic [DATA_WIDTH-1:0] r_mem [SIZE];
  state_t                r_state;
  logic [AW-1:0]         r_idx;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  w_wr_ok;
  logic                  w_core_en;
  fp32_t                 w_fp;

  assign w_wr_ok = wr_en && !r_busy && ({1'b0, wr_addr} < c_size);

  always_ff @(posedge s00_axi_aclk) begin
    if (w_wr_ok) r_mem[wr_addr] <= wr_data;
  end

  // Both core stages advance through FETCH and NORM; the ROUND-stage result is valid in ROUND.
  assign w_core_en = (r_state == ST_FETCH) || (r_state == ST_NORM);

  int2fp_core u_core (
    .clk    (s00_axi_aclk),
    .rst_n  (s00_axi_aresetn),
    .i_en   (w_core_en),
    .i_data (r_mem[r_idx]),
    .o_fp   (w_fp)
  );

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_tdata  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_FETCH;
            r_busy  <= 1'b1;
            r_idx   <= '0;
          end
        end
        ST_FETCH: r_state <= ST_NORM;
        ST_NORM:  r_state <= ST_ROUND;
        ST_ROUND: begin
          r_state  <= ST_SEND;
          r_tvalid <= 1'b1;
          r_tdata  <= w_fp;
          r_tlast  <= (r_idx == c_last_idx);
        end
        ST_SEND: begin
          if (m00_axis_tready) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            if (r_idx == c_last_idx) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + AW'(1);
              r_state <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_idx   <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign m00_axis_tvalid = r_tvalid;
  assign m00_axis_tdata  = r_tdata;
  assign m00_axis_tlast  = r_tlast;
  assign m00_axis_tstrb  = 4'hF;

endmodule

`default_nettype wire

// File: tb/tb_int2fp_stream_tx.sv
// ============================================================================
// Module      : tb_int2fp_stream_tx
// Description : Self-checking bench for int2fp_stream_tx with a reference model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_int2fp_stream_tx;

  localparam int SIZE = 5;
  localparam int AW   = $clog2(SIZE);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;
  logic          start = 1'b0;
  logic          busy, done, tvalid, tlast;
  logic [31:0]   tdata;
  logic [3:0]    tstrb;
  logic          tready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_w [SIZE];

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;
  vec_t vt [10];

  int2fp_stream_tx #(.SIZE(SIZE), .DATA_WIDTH(32), .AW(AW)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .m00_axis_tvalid (tvalid),
    .m00_axis_tdata  (tdata),
    .m00_axis_tstrb  (tstrb),
    .m00_axis_tlast  (tlast),
    .m00_axis_tready (tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Integer-arithmetic model: value = q * 2^s with q in [2^23, 2^24), rounded half-to-even.
  function automatic logic [31:0] ref_fp(input logic [31:0] x);
    longint m, q, rem, half;
    int p, s, e;
    logic sg;
    if (x == 32'd0) return 32'd0;
    sg = x[31];
    m  = sg ? (64'sd4294967296 - longint'(x)) : longint'(x);
    p  = 0;
    while ((m >> (p + 1)) > 0) p++;
    if (p <= 23) begin
      q = m * (64'sd1 << (23 - p));
      e = 127 + p;
    end else begin
      s    = p - 23;
      q    = m / (64'sd1 << s);
      rem  = m - q * (64'sd1 << s);
      half = 64'sd1 << (s - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == 64'sd16777216) begin
        q = q / 2;
        s++;
      end
      e = 150 + s;
    end
    return {sg, 8'(e), 23'(q % 64'sd8388608)};
  endfunction

  task automatic write_word(input int addr, input logic [31:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Runs one frame; timing=1 also checks start latency and the 3-cycle gaps (duty must be 100).
  task automatic run_frame(input int duty, input bit timing, input bit poke);
    int got, cyc, first, last_hs;
    logic pv, pr, pl;
    logic [31:0] pd;
    got = 0; first = -1; last_hs = -1; pv = 0; pr = 0; pl = 0; pd = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (got < SIZE && cyc < 500) begin
      if (cyc == 0) check("busy_after_start", {31'd0, busy}, 32'd1);
      if (tvalid && first < 0) first = cyc;
      if (pv && !pr) begin
        n_checks++;
        if (!(tvalid === 1'b1 && tdata === pd && tlast === pl)) begin
          n_errors++;
          $display("FAIL stall_stable: actual v=%b d=%h l=%b required v=1 d=%h l=%b",
                   tvalid, tdata, tlast, pd, pl);
        end
      end
      if (poke && cyc == 5) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 32'h1234_5678;
      end else if (poke && cyc == 6) begin
        start = 1'b0; wr_en = 1'b0;
      end
      tready = ($urandom_range(99) < duty);
      pv = tvalid; pr = tready; pd = tdata; pl = tlast;
      if (tvalid && tready) begin
        check($sformatf("word%0d_data", got), tdata, exp_w[got]);
        check($sformatf("word%0d_last", got), {31'd0, tlast}, {31'd0, got == SIZE - 1});
        if (timing && got > 0) check("gap_cycles", 32'(cyc - last_hs), 32'd4);
        last_hs = cyc;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    tready = 1'b0;
    if (got < SIZE) begin
      check("frame_timeout_words", 32'(got), 32'(SIZE));
      return;
    end
    if (timing) check("start_to_tvalid", 32'(first), 32'd3);
    check("done_pulse", {30'd0, done, busy}, 32'd3);
    @(negedge clk);
    check("after_done", {29'd0, done, busy, tvalid}, 32'd0);
  endtask

  initial begin
    int got, cyc;
    logic [31:0] v;

    vt[0] = '{32'd1,         32'h3F80_0000};
    vt[1] = '{32'hFFFF_FFFF, 32'hBF80_0000};
    vt[2] = '{32'd100,       32'h42C8_0000};
    vt[3] = '{32'd0,         32'h0000_0000};
    vt[4] = '{32'd55,        32'h425C_0000};
    vt[5] = '{32'h0100_0001, 32'h4B80_0000};
    vt[6] = '{32'h0100_0003, 32'h4B80_0002};
    vt[7] = '{32'h7FFF_FFFF, 32'h4F00_0000};
    vt[8] = '{32'h8000_0000, 32'hCF00_0000};
    vt[9] = '{32'd2,         32'h4000_0000};

    #12;
    check("rst_outputs", {28'd0, busy, done, tvalid, tlast}, 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("tstrb", {28'd0, tstrb}, 32'hF);
    @(negedge clk); rst_n = 1'b1;

    // Table frames: fixed values including the rounding corners.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < SIZE; i++) begin
        write_word(i, vt[f * SIZE + i].din);
        exp_w[i] = vt[f * SIZE + i].dout;
      end
      run_frame(100, 1'b1, 1'b0);
    end

    // Illegal start/write mid-frame, then an out-of-range write while idle.
    run_frame(100, 1'b0, 1'b1);
    write_word(SIZE, 32'hDEAD_BEEF);
    write_word(7, 32'hCAFE_F00D);
    run_frame(60, 1'b0, 1'b0);

    // Randomized frames under 30% tready duty against the model.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < SIZE; i++) begin
        v = $urandom() >> $urandom_range(31, 0);
        if ($urandom_range(1) == 1) v = -v;
        if ($urandom_range(9) == 0) v = 32'h8000_0000;
        write_word(i, v);
        exp_w[i] = ref_fp(v);
      end
      run_frame(30, 1'b0, 1'b0);
    end

    // Asynchronous reset while word 2 is presented and stalled.
    got = 0; cyc = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (cyc < 200) begin
      if (got == 2 && tvalid) break;
      tready = (got < 2);
      if (tvalid && tready) got++;
      @(negedge clk);
      cyc++;
    end
    tready = 1'b0;
    check("rst_test_reached_word2", {31'd0, tvalid}, 32'd1);
    check("rst_test_word2_data", tdata, exp_w[2]);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {28'd0, busy, done, tvalid, tlast}, 32'd0);
    check("async_rst_tdata", tdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_frame(100, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/int2fp_stream_tx.md
# int2fp_stream_tx

Transmit-side companion to the floating-point accumulator. It holds a buffer of `SIZE` signed 32-bit integers loaded over a simple write port. On `start` it converts each word to IEEE-754 single precision using round-to-nearest-even, then streams the results in order on an AXI-Stream master, with `tlast` on the final word. Its master port connects directly to the accumulator's `s00_axis` slave.

## Interface
- `SIZE`, 10: number of words per frame (≥2).
- `DATA_WIDTH`, 32: stream and buffer word width (fixed at 32 for conversion).
- `AW`, `$clog2(SIZE)`: write address width.

- `s00_axi_aclk` in 1: the single clock.
- `s00_axi_aresetn` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: buffer write strobe.
- `wr_addr` in AW: buffer write address.
- `wr_data` in 32: signed two's-complement sample.
- `start` in 1: begin a frame (level-sampled, acts only in IDLE).
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse after the last handshake.
- `m00_axis_tvalid` out 1: output word valid.
- `m00_axis_tdata` out 32: IEEE-754 single.
- `m00_axis_tstrb` out 4: constant `4'hF`.
- `m00_axis_tlast` out 1: high with word `SIZE-1`.
- `m00_axis_tready` in 1: downstream ready.

## Operation
- **Reset values:** `busy=0`, `done=0`, `tvalid=0`, `tlast=0`, `tdata=0`, FSM=IDLE, word index=0. Buffer contents are not reset.
- **Writes:** accepted only when `busy=0`. Writes while busy are ignored. Writes with `wr_addr ≥ SIZE` are ignored.
- **FSM:**
  - IDLE → FETCH on `start`.
  - FETCH: read `mem[idx]`.
  - NORM: sign, magnitude, leading-one position.
  - ROUND: shift, RNE, exponent.
  - SEND: hold `tvalid`.
  - SEND with `tvalid & tready`:
    - if `idx=SIZE-1` → DONE;
    - else `idx++` → FETCH.
  - DONE: `done=1` for one cycle, then → IDLE.
- **Conversion:**
  - Input 0 → `0x00000000`.
  - `sign = x[31]`; `mag = |x|` held in 32 bits unsigned, so `0x80000000` gives `mag = 2^31`.
  - `p` = index of the MSB of `mag`; `exp = 127 + p`.
  - If `p ≤ 23`: mantissa = `mag << (23-p)`, exact result.
  - Else: keep the top 24 bits. Guard = next bit; sticky = OR of the remaining bits. Round up if `guard & (sticky | lsb)`.
  - Mantissa carry-out → mantissa=0, `exp+1`.
  - No NaN, Inf or denormal outputs are possible.
- `start` while busy is ignored. `start` held high across DONE→IDLE launches a new frame.

## Timing
- `start` sampled at edge k → `tvalid` rises after edge k+3.
- After each non-last handshake, `tvalid` is low for 3 cycles, then the next word is presented.
- **Handshake rules:**
  - `tdata` and `tlast` are stable while `tvalid=1 & tready=0`.
  - `tvalid` never drops without a handshake.
  - `tready` may toggle freely, and may be high before `tvalid`.
- `busy` rises on the edge that leaves IDLE and falls on the edge DONE→IDLE. `done` and `busy` are high together for one cycle.
- Asynchronous reset mid-frame:
  - immediately forces `tvalid=0`, `busy=0`, FSM=IDLE;
  - no `tlast` or `done` is produced;
  - after reset the next `start` streams from index 0.

## Structure
- Package `fp_pkg`:
  - `FP_BIAS=127`, `FP_EXP_W=8`, `FP_MANT_W=23`;
  - FSM state enum;
  - `fp32_t` packed struct `{sign, exp, mant}`.
- Sub-module `int2fp_core`: two registered stages (NORM, ROUND) with an enable input. The top level owns the buffer, index counter, FSM and AXI-Stream handshake.

## Test plan
- **Basic frame:** load `SIZE=4` words {1, -1, 100, 0}, `start`, `tready=1`.
  - Required stream: `0x3F800000`, `0xBF800000`, `0x42C80000`, `0x00000000`.
  - `tlast` only on the 4th word; `done` pulse 1 cycle after the 4th handshake.
- **Rounding:**
  - `0x01000001` → `0x4B800000` (tie, stays even);
  - `0x01000003` → `0x4B800002` (tie, rounds up);
  - `0x7FFFFFFF` → `0x4F000000` (round carry into exponent);
  - `0x80000000` → `0xCF000000`.
- **Backpressure:** random `tready` at 30% duty. Check `tdata`/`tlast` stability while stalled, no dropped or duplicated words, and that the order matches the buffer.
- **Illegal activity while busy:** `start` mid-frame causes no restart. `wr_en` to address 0 mid-frame leaves the next frame's word 0 unchanged. `wr_addr=SIZE` leaves the buffer unchanged.
- **Reset mid-frame:** assert `s00_axi_aresetn=0` while `tvalid=1` on word 2. `tvalid` drops asynchronously and all outputs return to reset values. The next `start` streams from word 0.
- **Loopback:** connect to the accumulator with `SIZE=10` and inputs 1..10. Required accumulator result: `0x425C0000` (55.0).
